pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges stall sources into a per-stage hold mask,
// forwards jump redirects, adds a post-jump flush window, a JTAG halt drain and a stall counter.
module pipe_ctrl #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned STAGES       = 3,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned HALT_DRAIN   = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_flag_ex_i,
   input  logic              hold_flag_rib_i,
   input  logic              hold_flag_clint_i,
   input  logic              halt_req_jtag_i,
   input  logic              clr_cnt_i,
   output logic [STAGES-1:0] hold_flag_o,
   output logic              jump_flag_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              halt_ack_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam int unsigned CMAX = (FLUSH_CYCLES > HALT_DRAIN) ? FLUSH_CYCLES : HALT_DRAIN;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

   // PIPE holds every stage except the last; PC holds only the fetch address.
   localparam logic [STAGES-1:0] PIPE_MASK = {STAGES{1'b1}} >> 1;
   localparam logic [STAGES-1:0] PC_MASK   = STAGES'(1);

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      DRAIN,
      HALTED
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [STAGES-1:0] hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      // A jump restarts the flush window from any state except HALTED, where it is a debugger PC write.
      if (jump_flag_i && (FLUSH_CYCLES > 0) && (state != HALTED)) begin
         state_nx = FLUSH;
         cnt_nx   = CW'(FLUSH_CYCLES);
      end else begin
         case (state)
            IDLE: begin
               if (halt_req_jtag_i) begin
                  if (HALT_DRAIN > 0) begin
                     state_nx = DRAIN;
                     cnt_nx   = CW'(HALT_DRAIN);
                  end else begin
                     state_nx = HALTED;
                  end
               end
            end
            FLUSH: begin
               if (cnt == CW'(1)) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt - CW'(1);
               end
            end
            DRAIN: begin
               if (!halt_req_jtag_i) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (cnt == CW'(1)) begin
                  state_nx = HALTED;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt - CW'(1);
               end
            end
            HALTED: begin
               if (!halt_req_jtag_i) begin
                  state_nx = IDLE;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_comb begin
      hold = '0;
      if (jump_flag_i || hold_flag_ex_i || hold_flag_clint_i) begin
         hold = hold | PIPE_MASK;
      end
      if (hold_flag_rib_i) begin
         hold = hold | PC_MASK;
      end
      if ((state == FLUSH) || (state == HALTED)) begin
         hold = hold | PIPE_MASK;
      end
      if (state == DRAIN) begin
         hold = hold | PC_MASK;
      end
   end

   assign hold_flag_o = rst ? '0 : hold;
   assign jump_flag_o = rst ? 1'b0 : jump_flag_i;
   assign jump_addr_o = rst ? '0 : jump_addr_i;
   assign halt_ack_o  = !rst && (state == HALTED);

   always_ff @(posedge clk) begin
      if (rst || clr_cnt_i) begin
         stall_cnt_o <= '0;
      end else if (hold_flag_o[0] && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default, 3-cycle flush and 5-stage/2-bit-counter variants share stimulus.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump;
   logic [31:0] addr;
   logic        ex, rib, clint, halt, clr;

   logic [2:0]  h1, h3;
   logic [4:0]  h5;
   logic        jf1, jf3, jf5, ack1, ack3, ack5;
   logic [31:0] ja1, ja3, ja5, sc1, sc3;
   logic [1:0]  sc5;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .jump_flag_i(jump), .jump_addr_i(addr),
      .hold_flag_ex_i(ex), .hold_flag_rib_i(rib), .hold_flag_clint_i(clint),
      .halt_req_jtag_i(halt), .clr_cnt_i(clr),
      .hold_flag_o(h1), .jump_flag_o(jf1), .jump_addr_o(ja1),
      .halt_ack_o(ack1), .stall_cnt_o(sc1)
   );

   pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .jump_flag_i(jump), .jump_addr_i(addr),
      .hold_flag_ex_i(ex), .hold_flag_rib_i(rib), .hold_flag_clint_i(clint),
      .halt_req_jtag_i(halt), .clr_cnt_i(clr),
      .hold_flag_o(h3), .jump_flag_o(jf3), .jump_addr_o(ja3),
      .halt_ack_o(ack3), .stall_cnt_o(sc3)
   );

   pipe_ctrl #(.STAGES(5), .CNT_W(2)) dut5 (
      .clk(clk), .rst(rst), .jump_flag_i(jump), .jump_addr_i(addr),
      .hold_flag_ex_i(ex), .hold_flag_rib_i(rib), .hold_flag_clint_i(clint),
      .halt_req_jtag_i(halt), .clr_cnt_i(clr),
      .hold_flag_o(h5), .jump_flag_o(jf5), .jump_addr_o(ja5),
      .halt_ack_o(ack5), .stall_cnt_o(sc5)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; jump = 1'b1; addr = 32'h1234; ex = 1'b1; rib = 1'b1;
      clint = 1'b0; halt = 1'b1; clr = 1'b0;
      tick();
      #1;
      chk("rst_hold", 64'(h1), 64'(3'b000));
      chk("rst_jf", 64'(jf1), 64'(1'b0));
      chk("rst_ja", 64'(ja1), 64'(32'h0));
      chk("rst_ack", 64'(ack1), 64'(1'b0));
      jump = 1'b0; ex = 1'b0; rib = 1'b0; halt = 1'b0;
      tick();
      #1;
      chk("rst_cnt", 64'(sc1), 64'(0));

      // Jump with default one-cycle flush window
      tick(); rst = 1'b0; jump = 1'b1; addr = 32'h8000_0100; #1;
      chk("j_jf", 64'(jf1), 64'(1'b1));
      chk("j_ja", 64'(ja1), 64'(32'h8000_0100));
      chk("j_hold", 64'(h1), 64'(3'b011));
      tick(); jump = 1'b0; #1;
      chk("flush_hold", 64'(h1), 64'(3'b011));
      chk("flush_jf", 64'(jf1), 64'(1'b0));
      tick(); #1;
      chk("post_flush_hold", 64'(h1), 64'(3'b000));
      chk("post_flush_cnt", 64'(sc1), 64'(2));
      tick(); clr = 1'b1; #1;
      tick(); clr = 1'b0; #1;
      chk("clr_cnt", 64'(sc1), 64'(0));

      // Bus stall: PC only
      for (int i = 0; i < 4; i++) begin
         tick(); rib = 1'b1; #1;
         chk("rib_hold", 64'(h1), 64'(3'b001));
      end
      tick(); rib = 1'b0; #1;
      chk("rib_cnt", 64'(sc1), 64'(4));
      chk("rib_off_hold", 64'(h1), 64'(3'b000));
      tick(); clr = 1'b1; #1;
      tick(); clr = 1'b0; #1;
      chk("rib_clr", 64'(sc1), 64'(0));

      // Halt handshake
      tick(); halt = 1'b1; #1;
      chk("halt_c0_hold", 64'(h1), 64'(3'b000));
      tick(); #1;
      chk("halt_c1_hold", 64'(h1), 64'(3'b001));
      chk("halt_c1_ack", 64'(ack1), 64'(1'b0));
      tick(); #1;
      chk("halt_c2_hold", 64'(h1), 64'(3'b001));
      chk("halt_c2_ack", 64'(ack1), 64'(1'b0));
      tick(); #1;
      chk("halt_c3_hold", 64'(h1), 64'(3'b011));
      chk("halt_c3_ack", 64'(ack1), 64'(1'b1));
      tick(); halt = 1'b0; #1;
      chk("halt_drop_ack", 64'(ack1), 64'(1'b1));
      tick(); #1;
      chk("released_ack", 64'(ack1), 64'(1'b0));
      chk("released_hold", 64'(h1), 64'(3'b000));

      // Jump and halt together: flush first, then drain
      tick(); halt = 1'b1; jump = 1'b1; addr = 32'h40; #1;
      chk("jh_hold", 64'(h1), 64'(3'b011));
      tick(); jump = 1'b0; #1;
      chk("jh_flush_hold", 64'(h1), 64'(3'b011));
      chk("jh_flush_ack", 64'(ack1), 64'(1'b0));
      tick(); #1;
      chk("jh_idle_hold", 64'(h1), 64'(3'b000));
      tick(); #1;
      chk("jh_drain1", 64'(h1), 64'(3'b001));
      tick(); #1;
      chk("jh_drain2", 64'(h1), 64'(3'b001));
      chk("jh_drain2_ack", 64'(ack1), 64'(1'b0));
      tick(); #1;
      chk("jh_ack", 64'(ack1), 64'(1'b1));

      // Jump while halted: forwarded, state stays HALTED
      tick(); jump = 1'b1; addr = 32'h55; #1;
      chk("hj_ja", 64'(ja1), 64'(32'h55));
      chk("hj_jf", 64'(jf1), 64'(1'b1));
      tick(); jump = 1'b0; #1;
      chk("hj_still_ack", 64'(ack1), 64'(1'b1));
      chk("hj_still_hold", 64'(h1), 64'(3'b011));
      tick(); halt = 1'b0; #1;
      tick(); #1;
      chk("hj_release", 64'(ack1), 64'(1'b0));

      // Jump abandons drain
      tick(); halt = 1'b1; #1;
      tick(); #1;
      chk("jd_drain", 64'(h1), 64'(3'b001));
      tick(); jump = 1'b1; #1;
      chk("jd_jump_hold", 64'(h1), 64'(3'b011));
      tick(); jump = 1'b0; #1;
      chk("jd_flush_hold", 64'(h1), 64'(3'b011));
      chk("jd_flush_ack", 64'(ack1), 64'(1'b0));
      tick(); #1;
      chk("jd_idle_hold", 64'(h1), 64'(3'b000));
      tick(); halt = 1'b0; #1;
      chk("jd_redrain", 64'(h1), 64'(3'b001));
      tick(); #1;
      chk("jd_abort_hold", 64'(h1), 64'(3'b000));
      chk("jd_abort_ack", 64'(ack1), 64'(1'b0));

      // FLUSH_CYCLES=3: reload on last flush cycle
      tick(); rst = 1'b1; #1;
      tick(); rst = 1'b0; #1;
      chk("f3_rst_cnt", 64'(sc3), 64'(0));
      tick(); jump = 1'b1; #1;
      chk("f3_j", 64'(h3), 64'(3'b011));
      tick(); jump = 1'b0; #1;
      chk("f3_c1", 64'(h3), 64'(3'b011));
      tick(); #1;
      chk("f3_c2", 64'(h3), 64'(3'b011));
      tick(); jump = 1'b1; #1;
      chk("f3_c3_rejump", 64'(h3), 64'(3'b011));
      for (int i = 0; i < 3; i++) begin
         tick(); jump = 1'b0; #1;
         chk("f3_reload", 64'(h3), 64'(3'b011));
      end
      tick(); #1;
      chk("f3_end", 64'(h3), 64'(3'b000));
      chk("f3_cnt", 64'(sc3), 64'(7));

      // STAGES=5, CNT_W=2: wide mask, counter saturation, reset mid-drain
      tick(); rst = 1'b1; #1;
      tick(); rst = 1'b0; #1;
      for (int i = 0; i < 6; i++) begin
         tick(); ex = 1'b1; #1;
         chk("s5_hold", 64'(h5), 64'(5'b01111));
      end
      tick(); ex = 1'b0; #1;
      chk("s5_sat", 64'(sc5), 64'(2'b11));
      tick(); halt = 1'b1; #1;
      tick(); #1;
      chk("s5_drain", 64'(h5), 64'(5'b00001));
      tick(); rst = 1'b1; jump = 1'b1; addr = 32'hdead_beef; #1;
      chk("s5_rst_hold", 64'(h5), 64'(5'b00000));
      chk("s5_rst_jf", 64'(jf5), 64'(1'b0));
      chk("s5_rst_ja", 64'(ja5), 64'(32'h0));
      chk("s5_rst_ack", 64'(ack5), 64'(1'b0));
      tick(); #1;
      chk("s5_rst_cnt", 64'(sc5), 64'(0));
      tick(); rst = 1'b0; jump = 1'b0; halt = 1'b0; #1;
      chk("s5_idle_hold", 64'(h5), 64'(5'b00000));
      chk("s5_idle_ack", 64'(ack5), 64'(1'b0));
      tick(); #1;
      chk("s5_idle_hold2", 64'(h5), 64'(5'b00000));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
